iob_cache_back_end_arbiter: RTL and testbench

Shares the cache's single back-end IOB native memory port between two requesters: the write channel (write-through/write-back buffer drain) and the read channel (line refill). Fixed write priority with a bounded-starvation guarantee for refills; a refill burst owns the port from grant until its lock drops. Sits between the read/write channels and the back-end memory port, inside the cache back-end.

---
 rtl/iob_cache_back_end_arbiter.sv | 150 +++++++++++++++
 tb/tb_iob_cache_back_end_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/iob_cache_back_end_arbiter.sv
// Back-end port arbiter: fixed write priority with a bounded write streak, refill lock held until released.
// Optional watchdog on stalled back-end requests enabled by defining IOB_CACHE_BE_ARB_WDOG_EN.
module iob_cache_back_end_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int W_STREAK  = 4,
    parameter int TIMEOUT_W = 8
) (
    input  logic                clk_i,
    input  logic                arst_n_i,
    input  logic                w_valid_i,
    input  logic [ADDR_W-1:0]   w_addr_i,
    input  logic [DATA_W-1:0]   w_wdata_i,
    input  logic [DATA_W/8-1:0] w_wstrb_i,
    output logic                w_ack_o,
    input  logic                r_valid_i,
    input  logic                r_lock_i,
    input  logic [ADDR_W-1:0]   r_addr_i,
    output logic                r_ack_o,
    output logic [DATA_W-1:0]   r_rdata_o,
    output logic                be_valid_o,
    output logic [ADDR_W-1:0]   be_addr_o,
    output logic [DATA_W-1:0]   be_wdata_o,
    output logic [DATA_W/8-1:0] be_wstrb_o,
    input  logic                be_ack_i,
    input  logic [DATA_W-1:0]   be_rdata_i,
    output logic                err_o,
    output logic [1:0]          dbg_state_o,
    output logic [3:0]          dbg_streak_o
);

    // Handshake: a requester holds valid until its ack; the back end acks one word per
    // cycle with be_ack_i, and the ack is forwarded only to the channel owning the port.

    if (W_STREAK < 1 || W_STREAK > 15 || TIMEOUT_W < 2) begin : g_param_check
        $error("iob_cache_back_end_arbiter: W_STREAK must be 1..15 and TIMEOUT_W >= 2");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_t;

    localparam logic [3:0] STREAK_MAX = 4'(W_STREAK);

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_streak;
    logic       w_streak_full;

    assign w_streak_full = (r_streak == STREAK_MAX);
    assign r_rdata_o     = be_rdata_i;
    assign dbg_state_o   = r_state;
    assign dbg_streak_o  = r_streak;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        be_valid_o = 1'b0;
        be_addr_o  = '0;
        be_wdata_o = '0;
        be_wstrb_o = '0;
        w_ack_o    = 1'b0;
        r_ack_o    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_valid_i && !(r_valid_i && w_streak_full)) begin
                    w_next = WRITE;
                end else if (r_valid_i) begin
                    w_next = READ;
                end
            end
            WRITE: begin
                be_valid_o = w_valid_i;
                be_addr_o  = w_addr_i;
                be_wdata_o = w_wdata_i;
                be_wstrb_o = w_wstrb_i;
                w_ack_o    = be_ack_i;
                if (be_ack_i) begin
                    w_next = IDLE;
                end
            end
            READ: begin
                be_valid_o = r_valid_i;
                be_addr_o  = r_addr_i;
                r_ack_o    = be_ack_i;
                // The lock keeps the grant across gaps between refill words.
                if (!r_lock_i && !r_valid_i) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Counts write grants taken while a read waits; saturates at W_STREAK.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_streak <= '0;
        end else if (r_state == IDLE) begin
            if (!r_valid_i || w_next == READ) begin
                r_streak <= '0;
            end else if (w_next == WRITE && !w_streak_full) begin
                r_streak <= r_streak + 4'd1;
            end
        end
    end

`ifdef IOB_CACHE_BE_ARB_WDOG_EN
    localparam logic [TIMEOUT_W-1:0] WDOG_MAX = '1;

    logic [TIMEOUT_W-1:0] r_wdog;
    logic [TIMEOUT_W-1:0] w_wdog_next;
    logic                 r_err;

    always_comb begin
        w_wdog_next = r_wdog;
        if (r_state == IDLE || be_ack_i) begin
            w_wdog_next = '0;
        end else if (be_valid_o && r_wdog != WDOG_MAX) begin
            w_wdog_next = r_wdog + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_wdog <= '0;
            r_err  <= 1'b0;
        end else begin
            r_wdog <= w_wdog_next;
            if (w_wdog_next == WDOG_MAX) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err_o = r_err;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_iob_cache_back_end_arbiter.sv
// Directed bench for iob_cache_back_end_arbiter: vector table plus starvation, reset and watchdog sequences.
module tb_iob_cache_back_end_arbiter;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_READ  = 2'd2;
    localparam logic [31:0] WD_XOR = 32'h5A5A_0000;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        w_valid, r_valid, r_lock, be_ack;
    logic [31:0] w_addr, w_wdata, r_addr, be_rdata;
    logic [3:0]  w_wstrb;
    logic        w_ack, r_ack, be_valid, err;
    logic [31:0] r_rdata, be_addr, be_wdata;
    logic [3:0]  be_wstrb;
    logic [1:0]  dbg_state;
    logic [3:0]  dbg_streak;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    iob_cache_back_end_arbiter #(
        .ADDR_W(32), .DATA_W(32), .W_STREAK(4), .TIMEOUT_W(4)
    ) dut (
        .clk_i(clk), .arst_n_i(arst_n),
        .w_valid_i(w_valid), .w_addr_i(w_addr), .w_wdata_i(w_wdata), .w_wstrb_i(w_wstrb),
        .w_ack_o(w_ack),
        .r_valid_i(r_valid), .r_lock_i(r_lock), .r_addr_i(r_addr),
        .r_ack_o(r_ack), .r_rdata_o(r_rdata),
        .be_valid_o(be_valid), .be_addr_o(be_addr), .be_wdata_o(be_wdata), .be_wstrb_o(be_wstrb),
        .be_ack_i(be_ack), .be_rdata_i(be_rdata),
        .err_o(err), .dbg_state_o(dbg_state), .dbg_streak_o(dbg_streak)
    );

    typedef struct {
        logic        wv;
        logic [31:0] wa;
        logic        rv;
        logic        rl;
        logic [31:0] ra;
        logic        ack;
        logic [31:0] rd;
        logic        e_bv;
        logic [31:0] e_ba;
        logic [3:0]  e_ws;
        logic        e_wack;
        logic        e_rack;
        logic [1:0]  e_st;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic wv, input logic [31:0] wa, input logic rv, input logic rl,
                         input logic [31:0] ra, input logic ack, input logic [31:0] rd);
        w_valid  = wv;
        w_addr   = wa;
        w_wdata  = wa ^ WD_XOR;
        w_wstrb  = wv ? 4'hF : 4'h0;
        r_valid  = rv;
        r_lock   = rl;
        r_addr   = ra;
        be_ack   = ack;
        be_rdata = rd;
    endtask

    function automatic vec_t mk(input logic wv, input logic [31:0] wa, input logic rv, input logic rl,
                                input logic [31:0] ra, input logic ack, input logic [31:0] rd,
                                input logic e_bv, input logic [31:0] e_ba, input logic [3:0] e_ws,
                                input logic e_wack, input logic e_rack, input logic [1:0] e_st);
        vec_t v;
        v.wv = wv; v.wa = wa; v.rv = rv; v.rl = rl; v.ra = ra; v.ack = ack; v.rd = rd;
        v.e_bv = e_bv; v.e_ba = e_ba; v.e_ws = e_ws; v.e_wack = e_wack; v.e_rack = e_rack;
        v.e_st = e_st;
        return v;
    endfunction

    initial begin
        int writes;
        int max_streak;
        logic [1:0] first_grant;
        logic [31:0] e_wd;

        arst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);

        //            wv  wa      rv rl ra      ack rd          bv ba      ws    wack rack state
        vecs[0]  = mk(0, 32'h0,  0, 0, 32'h0,   1, 32'hDEAD, 0, 32'h0,   4'h0, 0, 0, S_IDLE);
        vecs[1]  = mk(1, 32'h40, 0, 0, 32'h0,   0, 32'h0,    0, 32'h0,   4'h0, 0, 0, S_IDLE);
        vecs[2]  = mk(1, 32'h40, 0, 0, 32'h0,   1, 32'h0,    1, 32'h40,  4'hF, 1, 0, S_WRITE);
        vecs[3]  = mk(0, 32'h0,  0, 0, 32'h0,   0, 32'h0,    0, 32'h0,   4'h0, 0, 0, S_IDLE);
        vecs[4]  = mk(0, 32'h0,  1, 1, 32'h100, 0, 32'h0,    0, 32'h0,   4'h0, 0, 0, S_IDLE);
        vecs[5]  = mk(1, 32'h80, 1, 1, 32'h100, 1, 32'h1111, 1, 32'h100, 4'h0, 0, 1, S_READ);
        vecs[6]  = mk(1, 32'h80, 1, 1, 32'h104, 1, 32'h2222, 1, 32'h104, 4'h0, 0, 1, S_READ);
        vecs[7]  = mk(1, 32'h80, 0, 1, 32'h108, 0, 32'h0,    0, 32'h108, 4'h0, 0, 0, S_READ);
        vecs[8]  = mk(1, 32'h80, 1, 1, 32'h108, 1, 32'h3333, 1, 32'h108, 4'h0, 0, 1, S_READ);
        vecs[9]  = mk(1, 32'h80, 1, 1, 32'h10C, 1, 32'h4444, 1, 32'h10C, 4'h0, 0, 1, S_READ);
        vecs[10] = mk(1, 32'h80, 0, 0, 32'h0,   0, 32'h0,    0, 32'h0,   4'h0, 0, 0, S_READ);
        vecs[11] = mk(1, 32'h80, 0, 0, 32'h0,   0, 32'h0,    0, 32'h0,   4'h0, 0, 0, S_IDLE);
        vecs[12] = mk(1, 32'h80, 0, 0, 32'h0,   0, 32'h0,    1, 32'h80,  4'hF, 0, 0, S_WRITE);
        vecs[13] = mk(1, 32'h80, 0, 0, 32'h0,   1, 32'h0,    1, 32'h80,  4'hF, 1, 0, S_WRITE);
        vecs[14] = mk(0, 32'h0,  0, 0, 32'h0,   0, 32'h0,    0, 32'h0,   4'h0, 0, 0, S_IDLE);

        // reset state
        repeat (2) @(posedge clk);
        #1;
        drive(1, 32'h40, 1, 1, 32'h100, 1, 32'h0);
        #1;
        chk("rst_be_valid", 32'(be_valid), 32'h0);
        chk("rst_be_addr", be_addr, 32'h0);
        chk("rst_be_wdata", be_wdata, 32'h0);
        chk("rst_be_wstrb", 32'(be_wstrb), 32'h0);
        chk("rst_w_ack", 32'(w_ack), 32'h0);
        chk("rst_r_ack", 32'(r_ack), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_state", 32'(dbg_state), 32'(S_IDLE));
        chk("rst_streak", 32'(dbg_streak), 32'h0);
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        arst_n = 1'b1;

        // table: single write, ack in IDLE ignored, locked refill with pending write, stalled write
        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].wv, vecs[i].wa, vecs[i].rv, vecs[i].rl, vecs[i].ra, vecs[i].ack, vecs[i].rd);
            #2;
            e_wd = (vecs[i].e_st == S_WRITE) ? (vecs[i].wa ^ WD_XOR) : 32'h0;
            chk($sformatf("v%0d_state", i), 32'(dbg_state), 32'(vecs[i].e_st));
            chk($sformatf("v%0d_be_valid", i), 32'(be_valid), 32'(vecs[i].e_bv));
            chk($sformatf("v%0d_be_addr", i), be_addr, vecs[i].e_ba);
            chk($sformatf("v%0d_be_wstrb", i), 32'(be_wstrb), 32'(vecs[i].e_ws));
            chk($sformatf("v%0d_be_wdata", i), be_wdata, e_wd);
            chk($sformatf("v%0d_w_ack", i), 32'(w_ack), 32'(vecs[i].e_wack));
            chk($sformatf("v%0d_r_ack", i), 32'(r_ack), 32'(vecs[i].e_rack));
            chk($sformatf("v%0d_r_rdata", i), r_rdata, vecs[i].rd);
            chk($sformatf("v%0d_err", i), 32'(err), 32'h0);
            tick();
        end
        chk("streak_after_table", 32'(dbg_streak), 32'h0);

        // starvation: writes and read requested together, back end acks immediately
        drive(1, 32'h300, 1, 0, 32'h200, 0, 32'h0);
        writes = 0;
        max_streak = 0;
        first_grant = S_IDLE;
        for (int c = 0; c < 40; c++) begin
            #2;
            if (dbg_state != S_IDLE && first_grant == S_IDLE) first_grant = dbg_state;
            if (int'(dbg_streak) > max_streak) max_streak = int'(dbg_streak);
            if (dbg_state == S_READ) break;
            if (dbg_state == S_WRITE) begin
                be_ack = 1'b1;
                #1;
                if (w_ack) writes++;
            end
            tick();
            be_ack = 1'b0;
        end
        chk("prio_first_grant", 32'(first_grant), 32'(S_WRITE));
        chk("starve_writes", 32'(writes), 32'd4);
        chk("starve_max_streak", 32'(max_streak), 32'd4);
        chk("starve_state", 32'(dbg_state), 32'(S_READ));
        chk("starve_streak_clr", 32'(dbg_streak), 32'h0);
        be_ack = 1'b1;
        be_rdata = 32'h7777;
        #1;
        chk("starve_r_ack", 32'(r_ack), 32'h1);
        chk("starve_w_ack", 32'(w_ack), 32'h0);
        chk("starve_rdata", r_rdata, 32'h7777);
        chk("starve_be_addr", be_addr, 32'h200);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        #1;
        chk("starve_back_idle", 32'(dbg_state), 32'(S_IDLE));

        // asynchronous reset while a refill is in flight
        drive(0, 0, 1, 1, 32'h400, 0, 0);
        tick();
        #1;
        chk("rstmid_be_valid_pre", 32'(be_valid), 32'h1);
        arst_n = 1'b0;
        #1;
        chk("rstmid_be_valid", 32'(be_valid), 32'h0);
        chk("rstmid_be_addr", be_addr, 32'h0);
        chk("rstmid_state", 32'(dbg_state), 32'(S_IDLE));
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        arst_n = 1'b1;
        tick();
        #1;
        chk("rstmid_after_state", 32'(dbg_state), 32'(S_IDLE));
        chk("rstmid_after_valid", 32'(be_valid), 32'h0);

`ifdef IOB_CACHE_BE_ARB_WDOG_EN
        // watchdog: write granted, back end never acks
        drive(1, 32'h500, 0, 0, 0, 0, 0);
        tick();
        repeat (14) tick();
        #1;
        chk("wdog_err_14", 32'(err), 32'h0);
        tick();
        #1;
        chk("wdog_err_15", 32'(err), 32'h1);
        be_ack = 1'b1;
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        #1;
        chk("wdog_err_sticky", 32'(err), 32'h1);
        chk("wdog_state", 32'(dbg_state), 32'(S_IDLE));
        arst_n = 1'b0;
        #1;
        chk("wdog_err_rst", 32'(err), 32'h0);
        tick();
        arst_n = 1'b1;
`endif

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
